serial_subtractor: RTL and testbench

//   Multi-cycle, bit-serial WIDTH-bit subtractor: diff = a - b - initial_borrow.

---
 rtl/serial_subtractor_pkg.sv | 18 +
 rtl/full_subtractor.sv | 13 +
 rtl/serial_subtractor.sv | 135 +++++++++++++
 tb/tb_serial_subtractor.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and bit-counter sizing.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Smallest r with 2**r >= value; sizes the bit counter so it can address bits 0..WIDTH-1.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: diff = a - b - bin, with borrow-out; the only arithmetic in the serial subtractor.
module full_subtractor (
  input  logic a_i,
  input  logic b_i,
  input  logic bin_i,
  output logic diff_o,
  output logic bout_o
);

  assign diff_o = a_i ^ b_i ^ bin_i;
  assign bout_o = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (diff = a - b - initial_borrow), one bit per clock, LSB first.
// Optional signed-overflow output is built when SUB_OVERFLOW_EN is defined.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             initial_borrow_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] diff_o,
  output logic             borrow_o
`ifdef SUB_OVERFLOW_EN
  ,
  output logic             overflow_o
`endif
);

  localparam int CNT_W = clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] opA_q, opB_q;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic             borrowFlop_q;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_q;
  logic             fsDiff, fsBout;
  logic             lastBit;

  // Operands shift right each SHIFT cycle, so bit 0 is always the bit currently being resolved.
  full_subtractor u_fullSub (
    .a_i    (opA_q[0]),
    .b_i    (opB_q[0]),
    .bin_i  (borrowFlop_q),
    .diff_o (fsDiff),
    .bout_o (fsBout)
  );

  assign shadow_d = {fsDiff, shadow_q[WIDTH-1:1]};
  assign lastBit  = (cnt_q == LAST_BIT);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_i) state_d = ST_SHIFT;
      ST_SHIFT: if (lastBit) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_o = 1'b0;
    done_o = 1'b0;
    case (state_q)
      ST_SHIFT: busy_o = 1'b1;
      ST_DONE: begin
        busy_o = 1'b1;
        done_o = 1'b1;
      end
      default: ;
    endcase
  end

  // Results are loaded only on the final SHIFT edge, so diff/borrow never expose partial values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q        <= '0;
      opA_q        <= '0;
      opB_q        <= '0;
      shadow_q     <= '0;
      borrowFlop_q <= 1'b0;
      diff_q       <= '0;
      borrow_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            opA_q        <= a_i;
            opB_q        <= b_i;
            borrowFlop_q <= initial_borrow_i;
            cnt_q        <= '0;
            shadow_q     <= '0;
          end
        end
        ST_SHIFT: begin
          opA_q        <= opA_q >> 1;
          opB_q        <= opB_q >> 1;
          shadow_q     <= shadow_d;
          borrowFlop_q <= fsBout;
          cnt_q        <= cnt_q + CNT_W'(1);
          if (lastBit) begin
            diff_q   <= shadow_d;
            borrow_q <= fsBout;
          end
        end
        default: ;
      endcase
    end
  end

  assign diff_o   = diff_q;
  assign borrow_o = borrow_q;

`ifdef SUB_OVERFLOW_EN
  logic overflow_q;

  // On the last bit, borrowFlop_q still holds the borrow into the MSB.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      overflow_q <= 1'b0;
    end else if (state_q == ST_SHIFT && lastBit) begin
      overflow_q <= borrowFlop_q ^ fsBout;
    end
  end

  assign overflow_o = overflow_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=4): directed table, handshake corner cases, random vs. arithmetic model.
module tb_serial_subtractor;

  localparam int WIDTH = 4;
  localparam int MOD   = 1 << WIDTH;
  localparam int HALF  = 1 << (WIDTH - 1);

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ib;
    logic [WIDTH-1:0] expDiff;
    logic             expBorrow;
    logic             expOvf;
  } vector_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a, b;
  logic             ib;
  logic             busy, done, borrow;
  logic [WIDTH-1:0] diff;
`ifdef SUB_OVERFLOW_EN
  logic             overflow;
`endif

  int testsRun    = 0;
  int testsFailed = 0;
  int doneTotal   = 0;

  logic [WIDTH-1:0] resDiff;
  logic             resBorrow;
  logic             resOvf;
  int               busyCycles, doneCount, doneIdx;
  logic             partialSeen, timedOut;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .start_i          (start),
    .a_i              (a),
    .b_i              (b),
    .initial_borrow_i (ib),
    .busy_o           (busy),
    .done_o           (done),
    .diff_o           (diff),
    .borrow_o         (borrow)
`ifdef SUB_OVERFLOW_EN
    ,
    .overflow_o       (overflow)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (done === 1'b1) doneTotal++;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Starts one operation and follows it until busy drops, recording what was observed.
  task automatic applyStimulus(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb, input logic tib);
    logic [WIDTH-1:0] startDiff;
    logic             startBorrow;
    @(negedge clk);
    a = ta; b = tb; ib = tib; start = 1'b1;
    startDiff   = diff;
    startBorrow = borrow;
    @(negedge clk);
    start = 1'b0;
    a  = WIDTH'($urandom);
    b  = WIDTH'($urandom);
    ib = 1'($urandom);
    busyCycles = 0; doneCount = 0; doneIdx = 0;
    partialSeen = 1'b0; timedOut = 1'b1;
    resDiff = 'x; resBorrow = 1'bx; resOvf = 1'bx;
    for (int c = 0; c < 4 * WIDTH + 8; c++) begin
      if (busy !== 1'b1) begin
        timedOut = 1'b0;
        break;
      end
      busyCycles++;
      if (done === 1'b1) begin
        doneCount++;
        doneIdx   = busyCycles;
        resDiff   = diff;
        resBorrow = borrow;
`ifdef SUB_OVERFLOW_EN
        resOvf    = overflow;
`endif
      end else if (doneCount == 0 && (diff !== startDiff || borrow !== startBorrow)) begin
        partialSeen = 1'b1;
      end
      @(negedge clk);
    end
  endtask

  task automatic checkOp(input string name, input logic [WIDTH-1:0] expDiff, input logic expBorrow,
                         input logic expOvf);
    checkOutput({name, " timeout"}, 32'(timedOut), 32'd0);
    checkOutput({name, " diff"}, 32'(resDiff), 32'(expDiff));
    checkOutput({name, " borrow"}, 32'(resBorrow), 32'(expBorrow));
`ifdef SUB_OVERFLOW_EN
    checkOutput({name, " overflow"}, 32'(resOvf), 32'(expOvf));
`else
    if (expOvf === 1'bx) $display("[TB] note: %s has undefined overflow expectation", name);
`endif
    checkOutput({name, " busyCycles"}, 32'(busyCycles), 32'(WIDTH + 1));
    checkOutput({name, " doneCount"}, 32'(doneCount), 32'd1);
    checkOutput({name, " doneIdx"}, 32'(doneIdx), 32'(WIDTH + 1));
    checkOutput({name, " noPartial"}, 32'(partialSeen), 32'd0);
    checkOutput({name, " heldDiff"}, 32'(diff), 32'(expDiff));
  endtask

  // Reference: plain integer arithmetic, unsigned for borrow, signed range check for overflow.
  task automatic refModel(input int ta, input int tb, input int tib,
                          output logic [WIDTH-1:0] d, output logic br, output logic ov);
    int full, sa, sb, sres;
    full = ta - tb - tib;
    d    = WIDTH'(((full % MOD) + MOD) % MOD);
    br   = (full < 0);
    sa   = (ta >= HALF) ? ta - MOD : ta;
    sb   = (tb >= HALF) ? tb - MOD : tb;
    sres = sa - sb - tib;
    ov   = (sres < -HALF) || (sres > HALF - 1);
  endtask

  vector_t vectors[8];

  initial begin
    int d0;
    logic [WIDTH-1:0] mDiff;
    logic mBorrow, mOvf;
    logic [WIDTH-1:0] ra, rb;
    logic rib;

    vectors[0] = '{4'd7,  4'd3,  1'b0, 4'd4,  1'b0, 1'b0};
    vectors[1] = '{4'd3,  4'd7,  1'b0, 4'hC,  1'b1, 1'b0};
    vectors[2] = '{4'd0,  4'd0,  1'b1, 4'hF,  1'b1, 1'b0};
    vectors[3] = '{4'd8,  4'd1,  1'b0, 4'd7,  1'b0, 1'b1};
    vectors[4] = '{4'hF,  4'hF,  1'b1, 4'hF,  1'b1, 1'b0};
    vectors[5] = '{4'd7,  4'hF,  1'b0, 4'd8,  1'b1, 1'b1};
    vectors[6] = '{4'd8,  4'd0,  1'b1, 4'd7,  1'b0, 1'b1};
    vectors[7] = '{4'd5,  4'd5,  1'b0, 4'd0,  1'b0, 1'b0};

    rst = 1'b1; start = 1'b0; a = '0; b = '0; ib = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset diff", 32'(diff), 32'd0);
    checkOutput("reset borrow", 32'(borrow), 32'd0);
`ifdef SUB_OVERFLOW_EN
    checkOutput("reset overflow", 32'(overflow), 32'd0);
`endif
    rst = 1'b0;

    foreach (vectors[i]) begin
      applyStimulus(vectors[i].a, vectors[i].b, vectors[i].ib);
      checkOp($sformatf("vec%0d", i), vectors[i].expDiff, vectors[i].expBorrow, vectors[i].expOvf);
    end

    // Second start two cycles after the first lands while busy and must be dropped.
    d0 = doneTotal;
    @(negedge clk);
    a = 4'd9; b = 4'd2; ib = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 4'd1; b = 4'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 4 * WIDTH + 8; c++) begin
      if (busy !== 1'b1) break;
      @(negedge clk);
    end
    repeat (2 * WIDTH) @(negedge clk);
    checkOutput("ignore doneCount", 32'(doneTotal - d0), 32'd1);
    checkOutput("ignore diff", 32'(diff), 32'd7);
    checkOutput("ignore idle", 32'(busy), 32'd0);

    // Reset in the middle of SHIFT aborts without a done pulse and clears diff.
    d0 = doneTotal;
    @(negedge clk);
    a = 4'd5; b = 4'd1; ib = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("abort busy", 32'(busy), 32'd0);
    checkOutput("abort diff", 32'(diff), 32'd0);
    checkOutput("abort done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (WIDTH + 3) @(negedge clk);
    checkOutput("abort noDone", 32'(doneTotal - d0), 32'd0);
    checkOutput("abort idle", 32'(busy), 32'd0);
    applyStimulus(4'd5, 4'd1, 1'b0);
    checkOp("afterAbort", 4'd4, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      ra  = WIDTH'($urandom);
      rb  = WIDTH'($urandom);
      rib = 1'($urandom);
      refModel(int'(ra), int'(rb), int'(rib), mDiff, mBorrow, mOvf);
      applyStimulus(ra, rb, rib);
      checkOp($sformatf("rand%0d", i), mDiff, mBorrow, mOvf);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
